// File: rtl/pixel_stream_capture.sv
// Pixel stream capture: locks onto a valid pixel stream, samples one byte every
// SAMPLE_PERIOD clocks into an internal frame memory and supports registered readback.
module pixel_stream_capture #(
  parameter int IMG_W         = 223,
  parameter int IMG_H         = 223,
  parameter int SAMPLE_PERIOD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        data_valid,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun,
  output logic [15:0] pixel_count,
  output logic [23:0] checksum,
  input  logic [15:0] rd_addr,
  output logic [7:0]  rd_data
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PW   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [15:0]   LAST_COL   = 16'(IMG_W - 1);
  localparam logic [15:0]   LAST_ROW   = 16'(IMG_H - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] LOCK_PHASE = (SAMPLE_PERIOD > 1) ? PW'(1) : '0;
  localparam logic [16:0]   NPIX_EXT   = 17'(NPIX);

  typedef enum logic [1:0] {IDLE, WAIT_VALID, CAPTURE, DONE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [15:0]   row_q, row_d;
  logic [15:0]   col_q, col_d;
  logic [15:0]   pixel_count_q, pixel_count_d;
  logic [23:0]   checksum_q, checksum_d;
  logic          underrun_q, underrun_d;
  logic [7:0]    rd_data_q, rd_data_d;

  logic [7:0]    mem [NPIX];
  logic          sample;
  logic          arm;
  logic          last_pixel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      row_q         <= '0;
      col_q         <= '0;
      pixel_count_q <= '0;
      checksum_q    <= '0;
      underrun_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      row_q         <= row_d;
      col_q         <= col_d;
      pixel_count_q <= pixel_count_d;
      checksum_q    <= checksum_d;
      underrun_q    <= underrun_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // The lock edge in WAIT_VALID is itself the first sample (pixel 0).
  always_comb begin
    state_d    = state_q;
    arm        = 1'b0;
    sample     = 1'b0;
    last_pixel = (row_q == LAST_ROW) && (col_q == LAST_COL);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WAIT_VALID;
          arm     = 1'b1;
        end
      end
      WAIT_VALID: begin
        if (data_valid) begin
          state_d = CAPTURE;
          sample  = 1'b1;
        end
      end
      CAPTURE: sample = (phase_q == '0);
      default: state_d = IDLE;
    endcase
    if (sample && last_pixel) state_d = DONE;
  end

  always_comb begin
    phase_d       = phase_q;
    row_d         = row_q;
    col_d         = col_q;
    pixel_count_d = pixel_count_q;
    checksum_d    = checksum_q;
    underrun_d    = underrun_q;
    if (arm) begin
      phase_d       = '0;
      row_d         = '0;
      col_d         = '0;
      pixel_count_d = '0;
      checksum_d    = '0;
      underrun_d    = 1'b0;
    end else begin
      if (state_q == WAIT_VALID && data_valid) begin
        phase_d = LOCK_PHASE;
      end else if (state_q == CAPTURE) begin
        phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
      end
      if (sample) begin
        pixel_count_d = pixel_count_q + 16'd1;
        checksum_d    = checksum_q + {16'd0, data_in};
        if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = row_q + 16'd1;
        end else begin
          col_d = col_q + 16'd1;
        end
        if (state_q == CAPTURE && !data_valid) underrun_d = 1'b1;
      end
    end
    rd_data_d = ({1'b0, rd_addr} < NPIX_EXT) ? mem[rd_addr[AW-1:0]] : '0;
  end

  // pixel_count always equals row*IMG_W+col, so it doubles as the write address.
  always_ff @(posedge clk) begin
    if (sample) mem[pixel_count_q[AW-1:0]] <= data_in;
  end

  always_comb begin
    busy        = (state_q == WAIT_VALID) || (state_q == CAPTURE);
    frame_done  = (state_q == DONE);
    underrun    = underrun_q;
    pixel_count = pixel_count_q;
    checksum    = checksum_q;
    rd_data     = rd_data_q;
  end

endmodule

// File: tb/tb_pixel_stream_capture.sv
// Scoreboard bench for pixel_stream_capture: a small frame with SAMPLE_PERIOD=4 and
// a 5x3 frame with SAMPLE_PERIOD=1, checked via per-sample counters and readback.
module tb_pixel_stream_capture;

  localparam int AW_W = 8;
  localparam int AW_H = 5;
  localparam int AP   = 4;
  localparam int AN   = AW_W * AW_H;
  localparam int BW   = 5;
  localparam int BH   = 3;
  localparam int BN   = BW * BH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, dv_a, busy_a, done_a, und_a;
  logic [7:0]  din_a, rdd_a;
  logic [15:0] rda_a, pc_a;
  logic [23:0] cs_a;

  logic        start_b, dv_b, busy_b, done_b, und_b;
  logic [7:0]  din_b, rdd_b;
  logic [15:0] rda_b, pc_b;
  logic [23:0] cs_b;

  pixel_stream_capture #(.IMG_W(AW_W), .IMG_H(AW_H), .SAMPLE_PERIOD(AP)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data_valid(dv_a), .data_in(din_a),
    .busy(busy_a), .frame_done(done_a), .underrun(und_a), .pixel_count(pc_a),
    .checksum(cs_a), .rd_addr(rda_a), .rd_data(rdd_a)
  );

  pixel_stream_capture #(.IMG_W(BW), .IMG_H(BH), .SAMPLE_PERIOD(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data_valid(dv_b), .data_in(din_b),
    .busy(busy_b), .frame_done(done_b), .underrun(und_b), .pixel_count(pc_b),
    .checksum(cs_b), .rd_addr(rda_b), .rd_data(rdd_b)
  );

  typedef struct {
    int         addr;
    logic [7:0] data;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] exp_mem [AN];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drain_a();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rda_a = 16'(e.addr);
      @(negedge clk);
      check_eq($sformatf("rd_a[%0d]", e.addr), rdd_a, e.data);
    end
    rda_a = 16'(AN);
    @(negedge clk);
    check_eq("rd_a_oob", rdd_a, 0);
    rda_a = 16'hFFFF;
    @(negedge clk);
    check_eq("rd_a_max", rdd_a, 0);
  endtask

  // mode 0: (row+col) pattern, 1: constant 0xFF, 2: underrun window, 3: stray start pulses
  task automatic run_frame_a(input int mode, input int abort_at, input bit rdw);
    int         since, p;
    bit         locked, und, pend, smp;
    logic [23:0] sum;
    logic [7:0] old;
    @(negedge clk);
    start_a = 1'b1;
    dv_a    = 1'b0;
    @(negedge clk);
    start_a = 1'b0;
    check_eq("arm_busy", busy_a, 1);
    check_eq("arm_done", done_a, 0);
    check_eq("arm_pc", pc_a, 0);
    check_eq("arm_cs", cs_a, 0);
    check_eq("arm_und", und_a, 0);
    locked = 0; since = 0; p = 0; sum = '0; und = 0; pend = 0; old = '0;
    for (int cyc = 0; cyc < 2000 && p < AN; cyc++) begin
      dv_a    = (locked || cyc >= 10) && !(mode == 2 && locked && since >= 50 && since < 58);
      smp     = locked ? (since % AP == 0) : dv_a;
      start_a = (mode == 3 && locked && (since == 30 || since == 32));
      din_a   = (mode == 1) ? 8'hFF : 8'($urandom);
      if (smp) begin
        if (mode == 0 || mode == 3) din_a = 8'((p / AW_W + p % AW_W) & 255);
        if (rdw && p == 9) begin
          rda_a = 16'(p);
          old   = exp_mem[p];
          pend  = 1;
        end
        if (!dv_a) und = 1;
        sum        = sum + {16'd0, din_a};
        exp_mem[p] = din_a;
        sb.push_back('{p, din_a});
      end
      @(negedge clk);
      start_a = 1'b0;
      if (locked) since++;
      else if (smp) begin
        locked = 1;
        since  = 1;
      end
      if (smp) begin
        p++;
        check_eq("pix_count", pc_a, p);
        check_eq("checksum_run", cs_a, sum);
        if (pend) begin
          check_eq("rd_during_wr", rdd_a, old);
          pend = 0;
        end
        if (p == AN / 2) check_eq("mid_busy", busy_a, 1);
        if (abort_at == p) begin
          #2 rst = 1'b1;
          #1;
          check_eq("rst_busy", busy_a, 0);
          check_eq("rst_done", done_a, 0);
          check_eq("rst_und", und_a, 0);
          check_eq("rst_pc", pc_a, 0);
          check_eq("rst_cs", cs_a, 0);
          check_eq("rst_rd", rdd_a, 0);
          @(negedge clk);
          rst  = 1'b0;
          dv_a = 1'b1;
          repeat (3) @(negedge clk);
          check_eq("post_rst_idle", busy_a, 0);
          check_eq("post_rst_pc", pc_a, 0);
          dv_a = 1'b0;
          sb.delete();
          return;
        end
      end else if (locked) begin
        check_eq("pc_hold", pc_a, p);
      end
    end
    dv_a = 1'b0;
    check_eq("frame_samples", p, AN);
    check_eq("frame_done", done_a, 1);
    check_eq("frame_busy", busy_a, 0);
    check_eq("frame_pc", pc_a, AN);
    check_eq("frame_cs", cs_a, sum);
    check_eq("frame_und", und_a, und);
    @(negedge clk);
    check_eq("done_hold", done_a, 1);
    drain_a();
  endtask

  initial begin
    sb_t e;
    rst = 1'b1;
    start_a = 0; dv_a = 0; din_a = 0; rda_a = 0;
    start_b = 0; dv_b = 0; din_b = 0; rda_b = 0;
    #2;
    check_eq("rst0_busy_a", busy_a, 0);
    check_eq("rst0_pc_a", pc_a, 0);
    check_eq("rst0_rd_a", rdd_a, 0);
    check_eq("rst0_done_b", done_b, 0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    dv_a = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_no_start", busy_a, 0);
    check_eq("idle_pc", pc_a, 0);
    dv_a = 1'b0;

    run_frame_a(0, -1, 0);
    run_frame_a(1, -1, 1);
    check_eq("cs_const_ff", cs_a, AN * 255);
    run_frame_a(2, -1, 1);
    run_frame_a(3, -1, 0);
    run_frame_a(0, 20, 0);
    run_frame_a(0, -1, 0);

    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check_eq("b_busy", busy_b, 1);
    for (int i = 0; i < BN; i++) begin
      dv_b  = 1'b1;
      din_b = 8'(8'h30 + i * 7);
      sb.push_back('{i, din_b});
      @(negedge clk);
      check_eq("b_done", done_b, (i == BN - 1));
      check_eq("b_pc", pc_b, i + 1);
    end
    dv_b = 1'b0;
    check_eq("b_und", und_b, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rda_b = 16'(e.addr);
      @(negedge clk);
      check_eq($sformatf("rd_b[%0d]", e.addr), rdd_b, e.data);
    end
    rda_b = 16'(BN);
    @(negedge clk);
    check_eq("rd_b_oob", rdd_b, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
